// File: rtl/stack_renderer.sv
// rtl/stack_renderer.sv - RGB332 tower renderer with per-frame stack snapshot and 2-clk pixel pipeline.
module stack_renderer #(
    parameter int         BLOCK_W    = 150,
    parameter int         BLOCK_H    = 20,
    parameter int         MAX_BLOCKS = 16,
    parameter int         H_VIS      = 640,
    parameter int         V_VIS      = 480,
    parameter logic [7:0] BG_COLOR   = 8'h00,
    parameter logic [7:0] EDGE_COLOR = 8'hFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              hcount,
    input  logic [9:0]              vcount,
    input  logic                    blank,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic [9:0]              pos_x,
    input  logic [9:0]              pos_y,
    input  logic [9:0]              height,
    input  logic [2*MAX_BLOCKS-1:0] colors,
    output logic [7:0]              rgb,
    output logic                    hsync_out,
    output logic                    vsync_out
);
    localparam int IDX_W = $clog2(MAX_BLOCKS);
    localparam int H_W   = $clog2(MAX_BLOCKS + 1);
    localparam int LX_W  = $clog2(BLOCK_W);
    localparam int LY_W  = $clog2(BLOCK_H);

    localparam logic [9:0]      MAX_H10  = 10'(MAX_BLOCKS);
    localparam logic [9:0]      H_VIS10  = 10'(H_VIS);
    localparam logic [9:0]      V_VIS10  = 10'(V_VIS);
    localparam logic [10:0]     BW11     = 11'(BLOCK_W);
    localparam logic [10:0]     BH11     = 11'(BLOCK_H);
    localparam logic [LX_W-1:0] LX_LAST  = LX_W'(BLOCK_W - 1);
    localparam logic [LY_W-1:0] LY_LAST  = LY_W'(BLOCK_H - 1);

    // Per-frame snapshot of the stack state
    logic [9:0]              snap_x;
    logic [9:0]              snap_y;
    logic [H_W-1:0]          snap_h;
    logic [2*MAX_BLOCKS-1:0] snap_colors;

    logic           frame_start;
    logic [H_W-1:0] h_clamped;

    assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);
    assign h_clamped   = (height > MAX_H10) ? H_W'(MAX_BLOCKS) : H_W'(height);

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_x      <= '0;
            snap_y      <= '0;
            snap_h      <= '0;
            snap_colors <= '0;
        end else if (frame_start) begin
            snap_x      <= pos_x;
            snap_y      <= pos_y;
            snap_h      <= h_clamped;
            snap_colors <= colors;
        end
    end

    // Stage 1: extent tests done in 11 bits so px+BLOCK_W never wraps
    logic [10:0]        x_end;
    logic signed [10:0] dy;
    logic [10:0]        span;
    logic               in_x;
    logic               in_y;
    logic               visible;

    assign x_end   = {1'b0, snap_x} + BW11;
    assign dy      = $signed({1'b0, snap_y}) - 11'sd1 - $signed({1'b0, vcount});
    assign span    = 11'(snap_h) * BH11;
    assign in_x    = (hcount >= snap_x) && ({1'b0, hcount} < x_end);
    assign in_y    = !dy[10] && (dy < $signed(span));
    assign visible = (hcount < H_VIS10) && (vcount < V_VIS10);

    logic                    blank1;
    logic                    hs1;
    logic                    vs1;
    logic                    inside1;
    logic [9:0]              dy1;
    logic [LX_W-1:0]         lx1;
    logic [2*MAX_BLOCKS-1:0] colors1;

    always_ff @(posedge clk) begin
        if (rst) begin
            blank1  <= 1'b1;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            inside1 <= 1'b0;
            dy1     <= '0;
            lx1     <= '0;
            colors1 <= '0;
        end else begin
            blank1  <= blank || !visible;
            hs1     <= hsync_in;
            vs1     <= vsync_in;
            inside1 <= in_x && in_y;
            dy1     <= dy[9:0];
            lx1     <= LX_W'(hcount - snap_x);
            colors1 <= snap_colors;
        end
    end

    // Stage 2: block index by comparator chain, then local row within the block
    logic [IDX_W-1:0] idx;
    logic [LY_W-1:0]  ly;
    logic [1:0]       code;
    logic             on_edge;
    logic [7:0]       fill;

    always_comb begin
        idx = '0;
        for (int k = 1; k < MAX_BLOCKS; k++) begin
            if (dy1 >= 10'(k * BLOCK_H))
                idx = IDX_W'(k);
        end
        ly   = LY_W'(dy1 - 10'(idx) * 10'(BLOCK_H));
        code = colors1[{idx, 1'b0} +: 2];
    end

    assign on_edge = (lx1 == '0) || (lx1 == LX_LAST) || (ly == '0) || (ly == LY_LAST);

    always_comb begin
        fill = BG_COLOR;
        case (code)
            2'b01:   fill = 8'hE0;
            2'b10:   fill = 8'h1C;
            2'b11:   fill = 8'h03;
            default: fill = BG_COLOR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb       <= 8'h00;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            hsync_out <= hs1;
            vsync_out <= vs1;
            if (blank1)
                rgb <= 8'h00;
            else if (!inside1 || code == 2'b00)
                rgb <= BG_COLOR;
            else if (on_edge)
                rgb <= EDGE_COLOR;
            else
                rgb <= fill;
        end
    end
endmodule
